pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline with ID-stage branch resolution.
// Tracks in-flight destinations in an EX/MEM/WB tag pipe; drives stall, forward selects and a stall counter.
module pipe_hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ext_hold_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              id_load_i,
    input  logic              id_branch_i,
    input  logic              cnt_clr_i,
    output logic              stall_o,
    output logic [1:0]        ex_fwd_a_o,
    output logic [1:0]        ex_fwd_b_o,
    output logic              id_fwd_a_o,
    output logic              id_fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef struct packed {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] rd;
    } wr_t;

    typedef struct packed {
        wr_t  w;
        logic ld;
    } tag_t;

    typedef struct packed {
        tag_t              t;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } ex_t;

    ex_t              ex;
    tag_t             mem;
    wr_t              wb;
    logic [CNT_W-1:0] cnt;

    logic stall;
    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;
    logic haz_a, haz_b;
    fwd_e fwd_a, fwd_b;

    // Register 0 is hardwired, so it never counts as a pending write.
    function automatic logic writer(input wr_t w, input logic [ADDR_W-1:0] r);
        return w.v & w.we & (w.rd != '0) & (w.rd == r);
    endfunction

    always_comb begin
        w_ex_a  = writer(ex.t.w, id_rs_i);
        w_ex_b  = writer(ex.t.w, id_rt_i);
        w_mem_a = writer(mem.w, id_rs_i);
        w_mem_b = writer(mem.w, id_rt_i);
        if (FWD_EN) begin
            haz_a = (w_ex_a & ex.t.ld) | (id_branch_i & w_ex_a) | (id_branch_i & w_mem_a & mem.ld);
            haz_b = (w_ex_b & ex.t.ld) | (id_branch_i & w_ex_b) | (id_branch_i & w_mem_b & mem.ld);
        end else begin
            haz_a = w_ex_a | w_mem_a;
            haz_b = w_ex_b | w_mem_b;
        end
        stall = id_valid_i & ((id_rs_used_i & haz_a) | (id_rt_used_i & haz_b));
    end

    // MEM result wins over WB because it is the younger write to the same register.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (ex.rs_used) begin
                if (writer(mem.w, ex.rs) && !mem.ld) fwd_a = FWD_MEM;
                else if (writer(wb, ex.rs))          fwd_a = FWD_WB;
            end
            if (ex.rt_used) begin
                if (writer(mem.w, ex.rt) && !mem.ld) fwd_b = FWD_MEM;
                else if (writer(wb, ex.rt))          fwd_b = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (!ext_hold_i) begin
            if (stall) begin
                ex <= '0;
            end else begin
                ex.t.w.v   <= id_valid_i;
                ex.t.w.we  <= id_we_i;
                ex.t.w.rd  <= id_rd_i;
                ex.t.ld    <= id_load_i;
                ex.rs      <= id_rs_i;
                ex.rt      <= id_rt_i;
                ex.rs_used <= id_rs_used_i;
                ex.rt_used <= id_rt_used_i;
            end
            mem <= ex.t;
            wb  <= mem.w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (cnt_clr_i) begin
            cnt <= '0;
        end else if (stall && !ext_hold_i && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stall_o     = stall;
    assign ex_fwd_a_o  = fwd_a;
    assign ex_fwd_b_o  = fwd_b;
    assign id_fwd_a_o  = FWD_EN & id_branch_i & id_rs_used_i & w_mem_a & ~mem.ld & ~stall;
    assign id_fwd_b_o  = FWD_EN & id_branch_i & id_rt_used_i & w_mem_b & ~mem.ld & ~stall;
    assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one forwarding instance and one interlock-only
// instance with a 2-bit counter, driven by shared hand-scheduled instruction sequences.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ext_hold = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic          id_we = 1'b0, id_load = 1'b0, id_branch = 1'b0;
    logic          cnt_clr = 1'b0;

    logic          stall, id_fwd_a, id_fwd_b;
    logic [1:0]    ex_fwd_a, ex_fwd_b;
    logic [15:0]   stall_cnt;

    logic          nf_stall, nf_id_fwd_a, nf_id_fwd_b;
    logic [1:0]    nf_ex_fwd_a, nf_ex_fwd_b;
    logic [1:0]    nf_cnt;

    int checks = 0;
    int errors = 0;
    logic running = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(AW), .FWD_EN(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .ext_hold_i(ext_hold), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load), .id_branch_i(id_branch),
        .cnt_clr_i(cnt_clr), .stall_o(stall), .ex_fwd_a_o(ex_fwd_a), .ex_fwd_b_o(ex_fwd_b),
        .id_fwd_a_o(id_fwd_a), .id_fwd_b_o(id_fwd_b), .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_ctrl #(.ADDR_W(AW), .FWD_EN(1'b0), .CNT_W(2)) dut_nf (
        .clk_i(clk), .rst_i(rst), .ext_hold_i(ext_hold), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load), .id_branch_i(id_branch),
        .cnt_clr_i(cnt_clr), .stall_o(nf_stall), .ex_fwd_a_o(nf_ex_fwd_a), .ex_fwd_b_o(nf_ex_fwd_b),
        .id_fwd_a_o(nf_id_fwd_a), .id_fwd_b_o(nf_id_fwd_b), .stall_cnt_o(nf_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic rsu,
                          input logic [AW-1:0] rt, input logic rtu, input logic [AW-1:0] rd,
                          input logic we, input logic ld, input logic br);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_we = we; id_load = ld; id_branch = br;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic flush();
        nop();
        repeat (3) step();
    endtask

    // A load in MEM must never be the forwarding source for an instruction in EX.
    always @(negedge clk) begin
        if (running && !rst) begin
            check("ld_in_mem_fwd",
                  {31'd0, (dut.ex.rs_used && dut.mem.ld && dut.mem.w.v && dut.mem.w.we &&
                           dut.mem.w.rd != '0 && dut.mem.w.rd == dut.ex.rs) ||
                          (dut.ex.rt_used && dut.mem.ld && dut.mem.w.v && dut.mem.w.we &&
                           dut.mem.w.rd != '0 && dut.mem.w.rd == dut.ex.rt)}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        settle();
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_fwd_a", {30'd0, ex_fwd_a}, 0);
        check("rst_fwd_b", {30'd0, ex_fwd_b}, 0);
        check("rst_idfwd", {30'd0, id_fwd_a, id_fwd_b}, 0);
        check("rst_cnt", {16'd0, stall_cnt}, 0);
        step();
        rst = 1'b0;
        step();

        // lw $2,0($1); add $3,$2,$4
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0);
        settle(); check("lu_lw_nostall", {31'd0, stall}, 0);
        step();
        set_id(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0, 0);
        settle(); check("lu_stall", {31'd0, stall}, 1);
        step();
        settle(); check("lu_stall_once", {31'd0, stall}, 0);
        step();
        nop();
        settle();
        check("lu_fwd_a", {30'd0, ex_fwd_a}, 1);
        check("lu_fwd_b", {30'd0, ex_fwd_b}, 0);
        check("lu_cnt", {16'd0, stall_cnt}, 1);
        flush();

        // add $2,$1,$1; sub $5,$2,$2
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0);
        step();
        set_id(1, 5'd2, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        settle(); check("alu_nostall", {31'd0, stall}, 0);
        step();
        nop();
        settle();
        check("alu_fwd_a", {30'd0, ex_fwd_a}, 2);
        check("alu_fwd_b", {30'd0, ex_fwd_b}, 2);
        check("alu_cnt", {16'd0, stall_cnt}, 1);
        flush();

        // add $2,$1,$1; beq $2,$0
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0);
        step();
        set_id(1, 5'd2, 1, 5'd0, 1, 5'd0, 0, 0, 1);
        settle();
        check("bra_stall", {31'd0, stall}, 1);
        check("bra_idfwd_dur", {31'd0, id_fwd_a}, 0);
        step();
        settle();
        check("bra_stall_end", {31'd0, stall}, 0);
        check("bra_idfwd_a", {31'd0, id_fwd_a}, 1);
        check("bra_idfwd_b", {31'd0, id_fwd_b}, 0);
        check("bra_cnt", {16'd0, stall_cnt}, 2);
        flush();

        // lw $2; beq $2,$0
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0);
        step();
        set_id(1, 5'd2, 1, 5'd0, 1, 5'd0, 0, 0, 1);
        settle(); check("brl_stall1", {31'd0, stall}, 1);
        step();
        settle(); check("brl_stall2", {31'd0, stall}, 1);
        step();
        settle();
        check("brl_stall3", {31'd0, stall}, 0);
        check("brl_idfwd_a", {31'd0, id_fwd_a}, 0);
        check("brl_cnt", {16'd0, stall_cnt}, 4);
        flush();

        // addi $0,$1,5; add $3,$0,$0
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        step();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0);
        settle(); check("r0_nostall", {31'd0, stall}, 0);
        step();
        nop();
        settle();
        check("r0_fwd_a", {30'd0, ex_fwd_a}, 0);
        check("r0_fwd_b", {30'd0, ex_fwd_b}, 0);

        // Counter clear
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        settle();
        check("clr_cnt", {16'd0, stall_cnt}, 0);
        check("clr_nf_cnt", {30'd0, nf_cnt}, 0);
        flush();

        // Interlock-only instance: add $2,$1,$1; add $3,$2,$2 twice (2-bit counter saturates)
        for (int unsigned i = 0; i < 2; i++) begin
            set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0);
            settle(); check("nf_first_nostall", {31'd0, nf_stall}, 0);
            step();
            set_id(1, 5'd2, 1, 5'd2, 1, 5'd3, 1, 0, 0);
            settle();
            check("nf_stall1", {31'd0, nf_stall}, 1);
            check("fw_nostall", {31'd0, stall}, 0);
            step();
            settle(); check("nf_stall2", {31'd0, nf_stall}, 1);
            step();
            settle(); check("nf_stall3", {31'd0, nf_stall}, 0);
            step();
            settle();
            check("nf_fwd", {28'd0, nf_ex_fwd_a, nf_ex_fwd_b}, 0);
            check("nf_idfwd", {30'd0, nf_id_fwd_a, nf_id_fwd_b}, 0);
            check("nf_cnt", {30'd0, nf_cnt}, (i == 0) ? 32'd2 : 32'd3);
        end
        check("fw_cnt_idle", {16'd0, stall_cnt}, 0);
        flush();

        // External hold during a lw/beq stall, then reset mid-stall
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0);
        step();
        set_id(1, 5'd2, 1, 5'd0, 1, 5'd0, 0, 0, 1);
        settle(); check("hold_pre_stall", {31'd0, stall}, 1);
        ext_hold = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            settle();
            check("hold_stall", {31'd0, stall}, 1);
            check("hold_cnt", {16'd0, stall_cnt}, 0);
        end
        ext_hold = 1'b0;
        step();
        settle();
        check("hold_rel_stall", {31'd0, stall}, 1);
        check("hold_rel_cnt", {16'd0, stall_cnt}, 1);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'd0, stall}, 0);
        check("midrst_cnt", {16'd0, stall_cnt}, 0);
        check("midrst_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 0);
        check("midrst_idfwd", {30'd0, id_fwd_a, id_fwd_b}, 0);
        step();
        rst = 1'b0;
        settle();
        check("postrst_stall", {31'd0, stall}, 0);
        step();
        settle();
        check("postrst_cnt", {16'd0, stall_cnt}, 0);

        running = 1'b0;
        nop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
